// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// It grants one byte per frame and keeps busy high for the whole frame.
module uart_tx_arbiter #(
    parameter int unsigned FRAME_CYCLES = 24,
    parameter int unsigned SEND_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       send,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam logic [7:0] SEND_LAST  = 8'(SEND_CYCLES - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAME_CYCLES - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       prio_reg;
    logic       pick;

    // Under contention the pointer decides; otherwise the lone requester wins.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = prio_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            prio_reg  <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            send      <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_reg <= SEND;
                        cnt_reg   <= 8'd0;
                        tx_data   <= pick ? data1 : data0;
                        grant_id  <= pick;
                        ack0      <= ~pick;
                        ack1      <= pick;
                        send      <= 1'b1;
                        busy      <= 1'b1;
                        prio_reg  <= ~pick;
                    end
                end
                SEND: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (cnt_reg == SEND_LAST) begin
                        send      <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt counts cycles since the grant edge, so busy spans exactly one frame.
                    cnt_reg <= cnt_reg + 8'd1;
                    if (cnt_reg == FRAME_LAST) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a grant-level model predicts who is served on which edge,
// and a monitor checks each ack against that prediction plus send/busy frame timing.
module tb_uart_tx_arbiter;

    localparam int FRAME = 24;
    localparam int SENDC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, send, busy, grant_id;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.FRAME_CYCLES(FRAME), .SEND_CYCLES(SENDC)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .send(send), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        bit         id;
        logic [7:0] data;
        int         edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   next_ok = 0;
    bit   prio_m = 1'b0;
    bit   rst_edge = 1'b0;

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endfunction

    // Reference model: a grant may happen once the arbiter is free, at most
    // one per FRAME+1 edges; contention is resolved by an alternating pointer.
    always @(posedge clk) begin
        exp_t e;
        edge_n = edge_n + 1;
        rst_edge = rst;
        if (rst) begin
            prio_m = 1'b0;
            next_ok = edge_n + 1;
        end else if (edge_n >= next_ok && (req0 || req1)) begin
            e.id = (req0 && req1) ? prio_m : req1;
            e.data = e.id ? data1 : data0;
            e.edge_no = edge_n;
            exp_q.push_back(e);
            prio_m = ~e.id;
            next_ok = edge_n + FRAME + 1;
        end
    end

    // Monitor
    int         send_len = 0;
    int         busy_len = 0;
    int         last_rise = -1;
    bit         prev_send = 1'b0;
    bit         prev_busy = 1'b0;
    logic [7:0] held = 8'h00;
    exp_t       got;

    always @(negedge clk) begin
        if (rst_edge) begin
            chk("rst_send", int'(send), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ack0", int'(ack0), 0);
            chk("rst_ack1", int'(ack1), 0);
            chk("rst_grant_id", int'(grant_id), 0);
            chk("rst_tx_data", int'(tx_data), 0);
            send_len = 0;
            busy_len = 0;
            last_rise = -1;
            prev_send = 1'b0;
            prev_busy = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
                chk("missing_ack", 0, 1);
                void'(exp_q.pop_front());
            end
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    $display("grant edge=%0d id=%0d data=%02h", edge_n, ack1, tx_data);
                    chk("ack_edge", edge_n, got.edge_no);
                    chk("ack_id", int'(ack1), int'(got.id));
                    chk("ack_onehot", int'(ack0 & ack1), 0);
                    chk("grant_id", int'(grant_id), int'(got.id));
                    chk("tx_data", int'(tx_data), int'(got.data));
                    chk("send_at_grant", int'(send), 1);
                    chk("busy_at_grant", int'(busy), 1);
                end
            end
            if (!busy) begin
                chk("idle_send_low", int'(send), 0);
                chk("idle_acks_low", int'(ack0 | ack1), 0);
            end
            if (send && !prev_send) begin
                if (last_rise >= 0) chk("send_gap", int'(edge_n - last_rise >= FRAME + 1), 1);
                last_rise = edge_n;
            end
            if (send) send_len++;
            else if (prev_send) begin
                chk("send_width", send_len, SENDC);
                send_len = 0;
            end
            if (busy) busy_len++;
            else if (prev_busy) begin
                chk("busy_width", busy_len, FRAME);
                busy_len = 0;
            end
            if (busy && prev_busy) chk("tx_data_hold", int'(tx_data), int'(held));
            held = tx_data;
            prev_send = send;
            prev_busy = busy;
        end
    end

    task automatic wait_ack(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if ((i == 0 && ack0) || (i == 1 && ack1)) ok = 1'b1;
        end
        if (!ok) chk("ack_timeout", 0, 1);
    endtask

    task automatic drive(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            if (!(i == 0 ? req0 : req1)) begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                if (i == 0) req0 = 1'b1; else req1 = 1'b1;
            end
            if (i == 0) data0 = 8'($urandom); else data1 = 8'($urandom);
            wait_ack(i);
            if ($urandom_range(0, 1) == 0 || k == n - 1) begin
                if (i == 0) req0 = 1'b0; else req1 = 1'b0;
            end
        end
    endtask

    int seq[4];
    int want_seq[4];

    initial begin
        want_seq[0] = 0; want_seq[1] = 1; want_seq[2] = 0; want_seq[3] = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single request
        data0 = 8'h41; req0 = 1'b1;
        wait_ack(0);
        req0 = 1'b0;
        repeat (30) @(negedge clk);

        // Contention right after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        data0 = 8'h30; data1 = 8'h31; req0 = 1'b1; req1 = 1'b1;
        wait_ack(0);
        req0 = 1'b0;
        wait_ack(1);
        req1 = 1'b0;
        repeat (30) @(negedge clk);

        // Round robin with both requests held
        data0 = 8'hA0; data1 = 8'hB1; req0 = 1'b1; req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            seq[g] = -1;
            for (int k = 0; k < 200 && seq[g] < 0; k++) begin
                @(negedge clk);
                if (ack0) seq[g] = 0;
                else if (ack1) seq[g] = 1;
            end
            chk("rr_order", seq[g], want_seq[g]);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (30) @(negedge clk);

        // Busy masking: req1 arrives mid-frame
        data0 = 8'h11; req0 = 1'b1;
        wait_ack(0);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        data1 = 8'h22; req1 = 1'b1;
        wait_ack(1);
        req1 = 1'b0;
        repeat (30) @(negedge clk);

        // Reset mid-frame; pointer must return to requester 0
        data0 = 8'h55; req0 = 1'b1;
        wait_ack(0);
        req0 = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'h56; data1 = 8'h66;
        @(negedge clk);
        rst = 1'b0;
        wait_ack(0);
        req0 = 1'b0;
        wait_ack(1);
        req1 = 1'b0;
        repeat (30) @(negedge clk);

        // Random traffic from both requesters, 8 bytes each
        fork
            drive(0, 8);
            drive(1, 8);
        join
        repeat (40) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
